// File: rtl/barrier_rasterizer_if.sv
// Command and write-beat bundle between a barrier-rasterizer client and the rasterizer.
// The rasterizer connects through the slave modport, the client through master.
interface barrier_rasterizer_if #(
  parameter int HPIXELS = 320,
  parameter int VPIXELS = 180
);
  localparam int HOR_SIZE  = $clog2(HPIXELS);
  localparam int VERT_SIZE = $clog2(VPIXELS);

  logic                 start_in;
  logic                 erase_in;
  logic [HOR_SIZE-1:0]  hor_start_in;
  logic [HOR_SIZE:0]    hor_end_in;
  logic [VERT_SIZE-1:0] vert_start_in;
  logic [VERT_SIZE:0]   vert_end_in;
  logic [HOR_SIZE-1:0]  hor_out;
  logic [VERT_SIZE-1:0] vert_out;
  logic                 value_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 busy_out;
  logic                 done_out;

  modport master (
    output start_in, erase_in, hor_start_in, hor_end_in, vert_start_in, vert_end_in, ready_in,
    input  hor_out, vert_out, value_out, valid_out, busy_out, done_out
  );

  modport slave (
    input  start_in, erase_in, hor_start_in, hor_end_in, vert_start_in, vert_end_in, ready_in,
    output hor_out, vert_out, value_out, valid_out, busy_out, done_out
  );
endinterface

// File: rtl/barrier_rasterizer.sv
// Walks a half-open rectangle [hs,he) x [vs,ve) in row-major order, emitting one
// (hor, vert, value) write beat per cell to paint or erase a barrier.
module barrier_rasterizer #(
  parameter int HPIXELS = 320,
  parameter int VPIXELS = 180
) (
  input logic            clk_in,
  input logic            rst_in,
  barrier_rasterizer_if.slave bus
);
  localparam int HOR_SIZE  = $clog2(HPIXELS);
  localparam int VERT_SIZE = $clog2(VPIXELS);
  localparam logic [HOR_SIZE:0]  HMAX = (HOR_SIZE+1)'(HPIXELS);
  localparam logic [VERT_SIZE:0] VMAX = (VERT_SIZE+1)'(VPIXELS);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t               state;
  logic [HOR_SIZE-1:0]  hs;
  logic [HOR_SIZE:0]    he;
  logic [VERT_SIZE-1:0] vs;
  logic [VERT_SIZE:0]   ve;

  logic [HOR_SIZE:0]    he_c;
  logic [VERT_SIZE:0]   ve_c;
  logic                 empty_c;
  logic                 hor_last;
  logic                 vert_last;

  function automatic logic [HOR_SIZE:0] clamp_hor(input logic [HOR_SIZE:0] e);
    return (e > HMAX) ? HMAX : e;
  endfunction

  function automatic logic [VERT_SIZE:0] clamp_vert(input logic [VERT_SIZE:0] e);
    return (e > VMAX) ? VMAX : e;
  endfunction

  // End compares run one bit wider than the counters so an end equal to the grid size still matches.
  always_comb begin
    he_c      = clamp_hor(bus.hor_end_in);
    ve_c      = clamp_vert(bus.vert_end_in);
    empty_c   = ({1'b0, bus.hor_start_in} >= he_c) || ({1'b0, bus.vert_start_in} >= ve_c);
    hor_last  = (({1'b0, bus.hor_out} + (HOR_SIZE+1)'(1)) == he);
    vert_last = (({1'b0, bus.vert_out} + (VERT_SIZE+1)'(1)) == ve);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      bus.hor_out   <= '0;
      bus.vert_out  <= '0;
      bus.value_out <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.busy_out  <= 1'b0;
      bus.done_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_in) begin
            hs            <= bus.hor_start_in;
            he            <= he_c;
            vs            <= bus.vert_start_in;
            ve            <= ve_c;
            bus.value_out <= ~bus.erase_in;
            if (empty_c) begin
              state        <= DONE;
              bus.done_out <= 1'b1;
            end else begin
              state         <= SCAN;
              bus.hor_out   <= bus.hor_start_in;
              bus.vert_out  <= bus.vert_start_in;
              bus.valid_out <= 1'b1;
              bus.busy_out  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (bus.valid_out && bus.ready_in) begin
            if (hor_last) begin
              if (vert_last) begin
                state         <= DONE;
                bus.valid_out <= 1'b0;
                bus.busy_out  <= 1'b0;
                bus.done_out  <= 1'b1;
              end else begin
                bus.hor_out  <= hs;
                bus.vert_out <= bus.vert_out + VERT_SIZE'(1);
              end
            end else begin
              bus.hor_out <= bus.hor_out + HOR_SIZE'(1);
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.done_out <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          bus.valid_out <= 1'b0;
          bus.busy_out  <= 1'b0;
          bus.done_out  <= 1'b0;
        end
      endcase
    end
  end
endmodule
